// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/execute) arbiter for the 8-bit memory bus with release cycle and timeout.
// Optional fetch starvation guard enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_bus_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd64,
    parameter logic [3:0] STARVE_LIMIT   = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic [7:0] f_addr,
    output logic       f_ready,
    output logic [7:0] f_rdata,
    input  logic       e_req,
    input  logic [7:0] e_addr,
    input  logic       e_we,
    input  logic [7:0] e_wdata,
    output logic       e_ready,
    output logic [7:0] e_rdata,
    output logic       err,
    output logic       gnt_f,
    output logic       gnt_e,
    output logic       mem_req,
    output logic [7:0] addr,
    output logic       we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_F,
        GRANT_E,
        RELEASE
    } state_t;

    state_t     state_q;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       timeout_hit;
    logic [7:0] cap_data;
    logic       pick_f;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] starve_q;
`else
    // Limit only matters when the starvation guard is built in.
    logic       unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    always_comb begin
        wait_d      = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (wait_d == TIMEOUT_CYCLES);
        cap_data    = mem_ready ? mem_rdata : 8'hFF;
`ifdef MEM_ARB_FAIRNESS_EN
        pick_f      = f_req && (!e_req || (starve_q == STARVE_LIMIT));
`else
        pick_f      = f_req && !e_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            mem_req   <= 1'b0;
            we        <= 1'b0;
            gnt_f     <= 1'b0;
            gnt_e     <= 1'b0;
            f_ready   <= 1'b0;
            e_ready   <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            e_rdata   <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
            starve_q  <= '0;
`endif
        end else begin
            f_ready <= 1'b0;
            e_ready <= 1'b0;
            err     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (e_req || f_req) begin
                        mem_req <= 1'b1;
                        wait_q  <= '0;
                        if (pick_f) begin
                            state_q   <= GRANT_F;
                            gnt_f     <= 1'b1;
                            addr      <= f_addr;
                            we        <= 1'b0;
                            mem_wdata <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
                            starve_q  <= '0;
`endif
                        end else begin
                            state_q   <= GRANT_E;
                            gnt_e     <= 1'b1;
                            addr      <= e_addr;
                            we        <= e_we;
                            mem_wdata <= e_wdata;
`ifdef MEM_ARB_FAIRNESS_EN
                            if (f_req && (starve_q != 4'hF)) begin
                                starve_q <= starve_q + 4'd1;
                            end
`endif
                        end
                    end
                end
                GRANT_F, GRANT_E: begin
                    // Completion takes precedence over a timeout on the same edge.
                    if (mem_ready || timeout_hit) begin
                        if (state_q == GRANT_F) begin
                            f_rdata <= cap_data;
                            f_ready <= 1'b1;
                        end else begin
                            e_rdata <= cap_data;
                            e_ready <= 1'b1;
                        end
                        err     <= !mem_ready;
                        mem_req <= 1'b0;
                        we      <= 1'b0;
                        gnt_f   <= 1'b0;
                        gnt_e   <= 1'b0;
                        state_q <= RELEASE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table with scoreboard plus corner-case sequences.
module tb_mem_bus_arbiter;

    localparam logic [7:0] TMO = 8'd8;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_req, e_req, e_we;
    logic [7:0] f_addr, e_addr, e_wdata;
    logic       f_ready, e_ready, err, gnt_f, gnt_e, mem_req, we;
    logic [7:0] f_rdata, e_rdata, addr, mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(4'd4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
        .e_req(e_req), .e_addr(e_addr), .e_we(e_we), .e_wdata(e_wdata),
        .e_ready(e_ready), .e_rdata(e_rdata), .err(err),
        .gnt_f(gnt_f), .gnt_e(gnt_e), .mem_req(mem_req), .addr(addr), .we(we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        bit         ex;
        bit         wr;
        logic [7:0] a;
        logic [7:0] wd;
        int         lat;
        logic [7:0] rd;
    } vec_t;

    typedef struct {
        bit         ex;
        bit         er;
        logic [7:0] rd;
        bit         chk_data;
    } exp_t;

    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    int         lat_cfg = 0;
    logic [7:0] rdata_cfg = 8'h00;
    logic [7:0] last_f, last_e;
    bit         last_e_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: raises mem_ready for the edge that ends the lat_cfg-th cycle of mem_req.
    initial begin
        int hi;
        hi = 0;
        mem_ready = 1'b0;
        mem_rdata = 8'hEE;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                hi++;
                mem_ready = (lat_cfg != 0) && (hi == lat_cfg);
            end else begin
                hi = 0;
                mem_ready = 1'b0;
            end
            mem_rdata = mem_ready ? rdata_cfg : 8'hEE;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_f = 8'h00;
        last_e = 8'h00;
        last_e_ok = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        exp_t e, got;
        int   hicnt;
        bit   done;
        lat_cfg   = v.lat;
        rdata_cfg = v.rd;
        e.ex       = v.ex;
        e.er       = (v.lat == 0);
        e.rd       = e.er ? 8'hFF : v.rd;
        e.chk_data = e.er || !(v.ex && v.wr);
        sb.push_back(e);
        if (v.ex) begin
            e_req = 1'b1; e_addr = v.a; e_we = v.wr; e_wdata = v.wd;
        end else begin
            f_req = 1'b1; f_addr = v.a;
        end
        hicnt = 0;
        done  = 1'b0;
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            @(posedge clk);
            #1;
            chk({nm, " ready exclusive"}, f_ready & e_ready, 0);
            chk({nm, " we without req"}, we & ~mem_req, 0);
            if (mem_req) begin
                if (hicnt == 0) begin
                    chk({nm, " grant latency"}, cyc, 1);
                    chk({nm, " addr"}, addr, v.a);
                    chk({nm, " we"}, we, v.ex ? v.wr : 1'b0);
                    chk({nm, " wdata"}, mem_wdata, v.ex ? v.wd : 8'h00);
                    chk({nm, " gnt"}, {gnt_f, gnt_e}, v.ex ? 2'b01 : 2'b10);
                end
                hicnt++;
            end
            if (f_ready || e_ready) begin
                done = 1'b1;
                f_req = 1'b0;
                e_req = 1'b0;
                chk({nm, " sb nonempty"}, sb.size(), 1);
                got = sb.pop_front();
                chk({nm, " ready source"}, {f_ready, e_ready}, got.ex ? 2'b01 : 2'b10);
                chk({nm, " err"}, err, got.er);
                chk({nm, " req dropped"}, {mem_req, gnt_f, gnt_e}, 0);
                if (got.chk_data) chk({nm, " rdata"}, got.ex ? e_rdata : f_rdata, got.rd);
                if (got.ex) begin
                    chk({nm, " f_rdata held"}, f_rdata, last_f);
                    last_e = got.rd;
                    last_e_ok = got.chk_data;
                end else begin
                    if (last_e_ok) chk({nm, " e_rdata held"}, e_rdata, last_e);
                    last_f = got.rd;
                end
            end
        end
        chk({nm, " ready seen"}, done, 1);
        chk({nm, " req cycles"}, hicnt, (v.lat == 0) ? 8 : v.lat);
        @(posedge clk);
        #1;
        chk({nm, " release"}, {mem_req, f_ready, e_ready, err}, 0);
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = 8'h00;
        e_req = 1'b0; e_addr = 8'h00; e_we = 1'b0; e_wdata = 8'h00;

        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 3, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h80, 8'h3C, 1, 8'h11};
        vecs[2] = '{1'b1, 1'b0, 8'h22, 8'h00, 2, 8'h5A};
        vecs[3] = '{1'b0, 1'b0, 8'h33, 8'h00, 0, 8'h12};
        vecs[4] = '{1'b1, 1'b0, 8'h40, 8'h00, 0, 8'h34};
        vecs[5] = '{1'b1, 1'b0, 8'h41, 8'h00, 8, 8'h77};
        vecs[6] = '{1'b0, 1'b0, 8'h7F, 8'h00, 7, 8'hC3};
        vecs[7] = '{1'b1, 1'b1, 8'hFE, 8'h81, 0, 8'h56};
        vecs[8] = '{1'b0, 1'b0, 8'h01, 8'h00, 1, 8'h5C};
        vecs[9] = '{1'b1, 1'b0, 8'hFF, 8'h00, 4, 8'hE1};

        do_reset();
        chk("reset ctrl", {mem_req, we, gnt_f, gnt_e, f_ready, e_ready, err}, 0);
        chk("reset data", {addr, mem_wdata, f_rdata, e_rdata}, 0);

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));
        chk("sb drained", sb.size(), 0);

        // Exec write and fetch requested together: exec first, fetch two cycles after e_ready.
        begin
            int  ngr, erc;
            bit  prev, fdone;
            do_reset();
            lat_cfg = 2; rdata_cfg = 8'h99;
            e_req = 1'b1; e_addr = 8'h80; e_we = 1'b1; e_wdata = 8'h3C;
            f_req = 1'b1; f_addr = 8'h10;
            ngr = 0; erc = -100; prev = 1'b0; fdone = 1'b0;
            for (int c = 0; c < 60 && !fdone; c++) begin
                @(posedge clk);
                #1;
                if (mem_req && !prev) begin
                    ngr++;
                    if (ngr == 1) begin
                        chk("prio first owner", {gnt_f, gnt_e, we}, 3'b011);
                        chk("prio exec addr/data", {addr, mem_wdata}, 16'h803C);
                    end else begin
                        chk("prio second owner", {gnt_f, gnt_e, we}, 3'b100);
                        chk("prio fetch addr", addr, 8'h10);
                        chk("prio fetch gap", c - erc, 2);
                    end
                end
                if (e_ready) begin
                    erc = c; e_req = 1'b0; e_we = 1'b0;
                end
                if (f_ready) begin
                    fdone = 1'b1; f_req = 1'b0;
                    chk("prio f_rdata", f_rdata, 8'h99);
                end
                prev = mem_req;
            end
            chk("prio fetch done", fdone, 1);
            chk("prio grants", ngr, 2);
        end

        // Reset while fetch is waiting: bus drops at once and no ready appears.
        begin
            bit seen;
            do_reset();
            lat_cfg = 0;
            f_req = 1'b1; f_addr = 8'h44;
            repeat (3) @(posedge clk);
            #1;
            chk("rstmid granted", {mem_req, gnt_f, addr}, {2'b11, 8'h44});
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rstmid ctrl", {mem_req, we, gnt_f, gnt_e, f_ready, e_ready, err}, 0);
            chk("rstmid data", {addr, mem_wdata, f_rdata, e_rdata}, 0);
            f_req = 1'b0; rst = 1'b0;
            seen = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (f_ready || mem_req) seen = 1'b1;
            end
            chk("rstmid quiet", seen, 0);
        end

        // Both requesters held continuously: grant order depends on the starvation guard.
        begin
            int  ng;
            bit  prev;
            bit  seq[10];
            do_reset();
            lat_cfg = 1; rdata_cfg = 8'h00;
            e_req = 1'b1; e_addr = 8'h20; e_we = 1'b0;
            f_req = 1'b1; f_addr = 8'h30;
            ng = 0; prev = 1'b0;
            for (int c = 0; c < 200 && ng < 10; c++) begin
                @(posedge clk);
                #1;
                if (mem_req && !prev) begin
                    seq[ng] = gnt_f;
                    ng++;
                end
                prev = mem_req;
            end
            e_req = 1'b0; f_req = 1'b0;
            chk("fair grant count", ng, 10);
            for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
                chk($sformatf("fair grant%0d is fetch", i), seq[i], (i % 5) == 4);
`else
                chk($sformatf("strict grant%0d is fetch", i), seq[i], 0);
`endif
            end
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
